// File: rtl/scope_rc_model_if.sv
// rtl/scope_rc_model_if.sv - AXI4-stream interface carrying the RC model sample streams
// Ready flows against the stream; data, valid and last flow with it.
interface axi4_stream_if #(
    parameter int DW = 14
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    modport source (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport drain (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/scope_rc_model.sv
// rtl/scope_rc_model.sv - single-pole RC low-pass forward model as a first-order IIR on a stream
// s tracks the output with DWC fractional bits; one accepted sample advances it once.
module scope_rc_model #(
    parameter int DWI = 14,
    parameter int DWO = 14,
    parameter int DWC = 18
) (
    input  logic               clk,
    input  logic               rstn,
    axi4_stream_if.drain       sti,
    axi4_stream_if.source      sto,
    input  logic [DWC-1:0]     cfg_aa,
    input  logic               ctl_rst
);
    localparam int SW = DWI + DWC;
    localparam int PW = SW + DWC + 2;

    logic [SW-1:0]  s_q, s_d;
    logic [DWO-1:0] data_q, data_d;
    logic           vld_q, vld_d;
    logic           last_q, last_d;

    logic           in_ready;
    logic           xfer;
    logic [SW:0]    err;
    logic [PW-1:0]  prod;
    logic [SW-1:0]  step;
    logic [SW-1:0]  s_new;

    // Backpressure only comes from a full, unaccepted output register.
    assign in_ready   = ~vld_q | sto.tready;
    assign xfer       = sti.tvalid & in_ready;
    assign sti.tready = in_ready;

    assign sto.tdata  = data_q;
    assign sto.tvalid = vld_q;
    assign sto.tlast  = last_q;

    // Modular product of sign-extended error and zero-extended coefficient equals
    // the signed product; taking bits above DWC is the floor shift.
    assign err   = {sti.tdata[DWI-1], sti.tdata, {DWC{1'b0}}} - {s_q[SW-1], s_q};
    assign prod  = {{(DWC + 1){err[SW]}}, err} * {{(SW + 2){1'b0}}, cfg_aa};
    assign step  = SW'(prod >> DWC);
    assign s_new = s_q + step;

    always_comb begin
        s_d    = s_q;
        data_d = data_q;
        vld_d  = vld_q;
        last_d = last_q;
        if (ctl_rst) begin
            s_d    = '0;
            data_d = '0;
            vld_d  = 1'b0;
            last_d = 1'b0;
        end else if (xfer) begin
            s_d    = s_new;
            data_d = s_new[SW-1 -: DWO];
            vld_d  = 1'b1;
            last_d = sti.tlast;
        end else if (sto.tready) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_q    <= '0;
            data_q <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            data_q <= data_d;
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end
endmodule

// File: tb/tb_scope_rc_model.sv
// tb/tb_scope_rc_model.sv - self-checking bench for scope_rc_model
// Expected outputs are pushed on accepted input and popped on accepted output.
module tb_scope_rc_model;
    localparam int DWI = 14;
    localparam int DWO = 14;
    localparam int DWC = 18;
    localparam int A_HALF = 1 << 17;
    localparam int A_MAX  = (1 << 18) - 1;

    typedef struct {
        longint data;
        bit     last;
    } exp_t;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           ctl_rst = 1'b0;
    logic [DWC-1:0] cfg_aa = '0;

    axi4_stream_if #(.DW(DWI)) sti ();
    axi4_stream_if #(.DW(DWO)) sto ();

    scope_rc_model #(.DWI(DWI), .DWO(DWO), .DWC(DWC)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .sti     (sti),
        .sto     (sto),
        .cfg_aa  (cfg_aa),
        .ctl_rst (ctl_rst)
    );

    always #5 clk = ~clk;

    int     n_chk = 0;
    int     n_pass = 0;
    exp_t   sb_q[$];
    longint obs_q[$];
    bit     obs_last_q[$];
    longint m_s = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Reference RC model: s += floor((x*2^18 - s) * a / 2^18), output = floor(s / 2^18).
    function automatic longint model_step(input longint x, input longint a);
        longint e;
        longint p;
        e = x * 262144 - m_s;
        p = e * a;
        m_s = m_s + (p >>> 18);
        return m_s >>> 18;
    endfunction

    always @(negedge clk) begin
        logic signed [DWO-1:0] d;
        exp_t ex;
        if (rstn && sto.tvalid && sto.tready) begin
            d = sto.tdata;
            obs_q.push_back(longint'(d));
            obs_last_q.push_back(sto.tlast);
            if (sb_q.size() == 0) begin
                check("sb_unexpected_output", longint'(d), 99999);
            end else begin
                ex = sb_q.pop_front();
                check("sb_data", longint'(d), ex.data);
                check("sb_last", longint'(sto.tlast), longint'(ex.last));
            end
        end
    end

    task automatic send(input int x, input bit last, input bit keep_valid);
        bit   acc;
        exp_t ex;
        acc = 1'b0;
        sti.tdata  = 14'(x);
        sti.tlast  = last;
        sti.tvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sti.tready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) check("send_timeout", 0, 1);
        ex.data = model_step(longint'(x), longint'(cfg_aa));
        ex.last = last;
        sb_q.push_back(ex);
        @(posedge clk);
        #1;
        if (!keep_valid) sti.tvalid = 1'b0;
    endtask

    task automatic hw_reset();
        sti.tvalid = 1'b0;
        sti.tlast  = 1'b0;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        m_s = 0;
        sb_q.delete();
        obs_q.delete();
        obs_last_q.delete();
    endtask

    task automatic drain(input string tag);
        sti.tvalid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0 && !sto.tvalid) break;
        end
        check(tag, longint'(sb_q.size()), 0);
    endtask

    initial begin
        longint exp2[6] = '{500, 750, 875, 937, 968, 984};
        int     stream4[12] = '{1000, -2000, 3000, 4000, -8000, 8191, 0, 77, -1, 6000, -6000, 250};
        logic [DWO-1:0] held;

        sti.tdata  = '0;
        sti.tvalid = 1'b0;
        sti.tlast  = 1'b0;
        sto.tready = 1'b1;

        // Reset state
        #2;
        check("rst_valid", longint'(sto.tvalid), 0);
        check("rst_data", longint'(sto.tdata), 0);
        check("rst_last", longint'(sto.tlast), 0);
        hw_reset();

        // 1: zero coefficient, one-cycle latency
        cfg_aa = '0;
        send(100, 1'b0, 1'b0);
        check("t1_latency_valid", longint'(sto.tvalid), 1);
        send(5000, 1'b0, 1'b0);
        send(-3000, 1'b1, 1'b0);
        drain("t1_drain");
        check("t1_count", longint'(obs_q.size()), 3);
        for (int i = 0; i < 3; i++) check("t1_zero", obs_q[i], 0);

        // 2: a=0.5 step response
        hw_reset();
        cfg_aa = DWC'(A_HALF);
        for (int i = 0; i < 6; i++) send(1000, 1'b0, 1'b1);
        drain("t2_drain");
        check("t2_count", longint'(obs_q.size()), 6);
        for (int i = 0; i < 6; i++) check("t2_step", obs_q[i], exp2[i]);

        // 3: full-scale coefficient, floor rounding at both rails
        hw_reset();
        cfg_aa = DWC'(A_MAX);
        send(8191, 1'b0, 1'b0);
        drain("t3a_drain");
        check("t3_pos_full", obs_q[0], 8190);
        hw_reset();
        send(-8192, 1'b0, 1'b0);
        drain("t3b_drain");
        check("t3_neg_full", obs_q[0], -8192);

        // 4: continuous stream with a 5-cycle output stall
        hw_reset();
        cfg_aa = DWC'(A_HALF);
        fork
            begin
                for (int i = 0; i < 12; i++) send(stream4[i], i == 11, 1'b1);
                sti.tvalid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                sto.tready = 1'b0;
                @(negedge clk);
                held = sto.tdata;
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    check("t4_stall_ready", longint'(sti.tready), 0);
                    check("t4_stall_valid", longint'(sto.tvalid), 1);
                    check("t4_stall_data", longint'(sto.tdata), longint'(held));
                end
                @(posedge clk);
                #1;
                sto.tready = 1'b1;
            end
        join
        drain("t4_drain");
        check("t4_count", longint'(obs_q.size()), 12);
        check("t4_last_flag", longint'(obs_last_q[11]), 1);

        // 5: ctl_rst after third output, with a discarded transfer in that cycle
        hw_reset();
        cfg_aa = DWC'(A_HALF);
        for (int i = 0; i < 3; i++) send(1000, 1'b0, 1'b1);
        drain("t5a_drain");
        check("t5_third", obs_q[2], 875);
        ctl_rst = 1'b1;
        sti.tdata  = 14'(5000);
        sti.tvalid = 1'b1;
        @(negedge clk);
        check("t5_ready_in_clear", longint'(sti.tready), 1);
        @(posedge clk);
        #1;
        ctl_rst = 1'b0;
        sti.tvalid = 1'b0;
        m_s = 0;
        check("t5_clear_valid", longint'(sto.tvalid), 0);
        check("t5_clear_last", longint'(sto.tlast), 0);
        send(1000, 1'b1, 1'b0);
        drain("t5b_drain");
        check("t5_after_clear", obs_q[3], 500);
        check("t5_last", longint'(obs_last_q[3]), 1);

        // 6: asynchronous reset mid-clock while holding a valid output
        hw_reset();
        cfg_aa = DWC'(A_HALF);
        sto.tready = 1'b0;
        send(3000, 1'b0, 1'b0);
        check("t6_held_valid", longint'(sto.tvalid), 1);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_async_valid", longint'(sto.tvalid), 0);
        check("t6_async_data", longint'(sto.tdata), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        sto.tready = 1'b1;
        m_s = 0;
        sb_q.delete();
        obs_q.delete();
        obs_last_q.delete();
        send(1000, 1'b0, 1'b0);
        drain("t6_drain");
        check("t6_first", obs_q[0], 500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/scope_rc_model.md
Name: scope_rc_model

Overview:
- Forward model of the scope analog input network: a single-pole RC low-pass, implemented as a first-order IIR on an AXI4-stream.
- It is the encoder counterpart of the scope_filter deconvolution. Feeding generator samples through it and then through scope_filter should give back the original stream.
- Used in simulation benches and as an optional ADC-path emulation stage ahead of the acquisition chain.
- Throughput is one sample per clock, with full backpressure support.

Parameters:
- DWI, 14, input sample width (signed).
- DWO, 14, output sample width (signed). Must satisfy DWO <= DWI.
- DWC, 18, coefficient width (unsigned fraction).

Ports:
- clk  input  1  clock, shared with the ACLK of both stream interfaces.
- rstn  input  1  reset, asynchronous, active-low.
- sti  axi4_stream_if (drain modport)  DWI  input stream: data, valid, ready, last.
- sto  axi4_stream_if (source modport)  DWO  output stream: data, valid, ready, last.
- cfg_aa  input  DWC  filter coefficient, unsigned. a = cfg_aa / 2^DWC.
- ctl_rst  input  1  synchronous clear of filter state and output register.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is asynchronous on rstn falling and active-low.
  - In reset: state s=0, sto.valid=0, sto.data=0, sto.last=0.
- State:
  - s is a signed register of DWI+DWC bits, representing the output with DWC fractional bits.
- Handshake:
  - sti.ready = ~sto.valid | sto.ready, combinational; it must not depend on sti.valid.
  - A transfer occurs when sti.valid & sti.ready.
- Update on transfer with input x:
  - e = (x <<< DWC) - s, signed, DWI+DWC+1 bits.
  - p = e * cfg_aa, signed, with cfg_aa zero-extended.
  - s <= s + (p >>> DWC). The shift is arithmetic, i.e. floor.
- Output register:
  - On the same edge, sto.data <= top DWO bits of the new s, i.e. s_next[DWI+DWC-1 -: DWO], truncated.
  - sto.last <= sti.last; sto.valid <= 1.
  - Latency is 1 cycle from transfer to sto.valid.
- Output release:
  - If sto.valid & sto.ready and there is no new transfer: sto.valid <= 0.
  - sto.data and sto.last hold their values while sto.valid=1 and sto.ready=0.
- Range:
  - Because 0 <= cfg_aa < 2^DWC, s stays within [min(x), max(x)] of the samples received.
  - No saturation logic is required.
- cfg_aa:
  - Sampled combinationally at each transfer.
  - A change between transfers takes effect on the next transfer, with no pipeline flush.
- ctl_rst=1:
  - Next edge: s <= 0, sto.valid <= 0, sto.last <= 0.
  - Any transfer presented in that cycle is accepted and discarded: sti.ready still follows the rule above.
  - ctl_rst has priority over all other updates.
- Simultaneous output release and new transfer: sto.valid stays 1 and data is replaced. No bubble.
- Idle:
  - With no transfer, s is unchanged.
  - State advances only on accepted samples, never on cycles alone.

Test Plan (DWI=DWO=14, DWC=18):
1. cfg_aa=0, sti sends 100, 5000, -3000 → sto.data = 0, 0, 0; each output valid 1 cycle after its transfer.
2. cfg_aa=2^17 (a=0.5), constant x=1000 for 6 samples from reset → sto.data = 500, 750, 875, 937, 968, 984.
3. cfg_aa=2^18-1:
   - x=8191 once from reset → sto.data = 8190.
   - After reset, x=-8192 → -8192.
   - Confirms floor rounding and that there is no overflow at full scale.
4. a=0.5, continuous sti.valid with sto.ready held low for 5 cycles mid-stream:
   - sti.ready=0 during the stall.
   - sto.data is stable.
   - After release, the sequence equals the unstalled reference; no sample is lost or duplicated.
5. a=0.5 with x=1000 stream, ctl_rst pulsed after the 3rd output (875):
   - Next output is computed from s=0, i.e. 500.
   - sto.last follows sti.last on the 4th sample.
6. Assert rstn low asynchronously mid-clock while sto.valid=1 → sto.valid=0 immediately. After release, the first x=1000 at a=0.5 gives 500.
